// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART constants: baud table, divider helper, oversample
//          sample points and FSM state encoding.
// Rev    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int c_os_rate = 16;
  localparam int c_div_w   = 16;

  // Sample points are the values os_cnt takes on the tick; 15 closes a bit.
  localparam logic [3:0] c_os_s0   = 4'd7;
  localparam logic [3:0] c_os_s1   = 4'd8;
  localparam logic [3:0] c_os_s2   = 4'd9;
  localparam logic [3:0] c_os_last = 4'd15;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_start = 2'd1;
  localparam logic [1:0] c_st_data  = 2'd2;
  localparam logic [1:0] c_st_stop  = 2'd3;

  typedef logic [2:0] baud_sel_t;

  localparam int c_baud_tbl [0:7] = '{9600, 19200, 38400, 57600,
                                      115200, 115200, 115200, 115200};

  function automatic int div_for(input int clk_freq, input int baud);
    return clk_freq / (baud * c_os_rate) - 1;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_sync
// Brief  : Two-flop synchroniser with a delayed copy for falling-edge detect.
// Rev    : 1.0 - initial release
// ============================================================================
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic n_reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_dly  <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_dly & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// ============================================================================
// Module : uart_byte_rx
// Brief  : 8N1 UART byte receiver, 16x oversampling with 3-sample majority.
// Rev    : 1.0 - initial release
// ============================================================================
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       uart_rx,
  input  logic [2:0] Baud_set,
  output logic [7:0] Data,
  output logic       Rx_done,
  output logic       Frame_err
);

  logic               w_rx;
  logic               w_fall;
  logic [1:0]         r_state;
  baud_sel_t          r_baud;
  logic [c_div_w-1:0] r_div;
  logic [c_div_w-1:0] w_div;
  logic [c_div_w-1:0] w_div_tbl [0:7];
  logic [3:0]         r_os;
  logic [3:0]         w_os_nxt;
  logic [2:0]         r_bit;
  logic [7:0]         r_shreg;
  logic               r_s0;
  logic               r_s1;
  logic               w_tick;
  logic               w_start;
  logic               w_vote;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .i_async (uart_rx),
    .o_sync  (w_rx),
    .o_fall  (w_fall)
  );

  // Divider reloads are constants per rate select; no runtime division.
  for (genvar g = 0; g < 8; g++) begin : g_div_tbl
    assign w_div_tbl[g] = c_div_w'(div_for(CLK_FREQ, c_baud_tbl[g]));
  end

  assign w_div    = w_div_tbl[r_baud];
  assign w_start  = (r_state == c_st_idle) && w_fall;
  assign w_tick   = (r_div >= w_div);
  assign w_os_nxt = r_os + 4'd1;
  assign w_vote   = maj3(r_s0, r_s1, w_rx);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_div <= '0;
      r_os  <= 4'd0;
    end else if (w_start) begin
      r_div <= '0;
      r_os  <= 4'd0;
    end else if (w_tick) begin
      r_div <= '0;
      r_os  <= w_os_nxt;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else if (w_tick) begin
      if (w_os_nxt == c_os_s0) r_s0 <= w_rx;
      if (w_os_nxt == c_os_s1) r_s1 <= w_rx;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state   <= c_st_idle;
      r_baud    <= '0;
      r_bit     <= 3'd0;
      r_shreg   <= 8'h00;
      Data      <= 8'h00;
      Rx_done   <= 1'b0;
      Frame_err <= 1'b0;
    end else begin
      Rx_done   <= 1'b0;
      Frame_err <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (w_fall) begin
            r_state <= c_st_start;
            r_baud  <= Baud_set;
            r_bit   <= 3'd0;
          end
        end
        c_st_start: begin
          if (w_tick) begin
            if (w_os_nxt == c_os_s2 && w_vote)
              r_state <= c_st_idle;
            else if (w_os_nxt == c_os_last)
              r_state <= c_st_data;
          end
        end
        c_st_data: begin
          if (w_tick) begin
            if (w_os_nxt == c_os_s2) begin
              r_shreg[r_bit] <= w_vote;
            end else if (w_os_nxt == c_os_last) begin
              r_bit <= r_bit + 3'd1;
              if (r_bit == 3'd7) r_state <= c_st_stop;
            end
          end
        end
        c_st_stop: begin
          // Leave mid stop bit so a start bit right behind it is still seen.
          if (w_tick && w_os_nxt == c_os_s2) begin
            if (w_vote) begin
              Data    <= r_shreg;
              Rx_done <= 1'b1;
            end else begin
              Frame_err <= 1'b1;
            end
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_uart_byte_rx
// Brief  : Directed self-checking bench for uart_byte_rx.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_uart_byte_rx;

  // 3.6864 MHz gives exact dividers: 384 clocks/bit at 9600, 32 at 115200.
  localparam int  CLK_FREQ = 3_686_400;
  localparam real CLK_NS   = 10.0;
  localparam real B0_NS    = 384.0 * CLK_NS;
  localparam real B4_NS    = 32.0 * CLK_NS;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       uart_rx = 1'b1;
  logic [2:0] Baud_set = 3'd0;
  logic [7:0] Data;
  logic       Rx_done;
  logic       Frame_err;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int wide_cnt = 0;
  int last_done_cyc = 0;
  logic [7:0] done_log [$];
  logic prev_done = 1'b0;
  logic prev_ferr = 1'b0;

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .uart_rx   (uart_rx),
    .Baud_set  (Baud_set),
    .Data      (Data),
    .Rx_done   (Rx_done),
    .Frame_err (Frame_err)
  );

  always #(CLK_NS / 2.0) clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (Rx_done) begin
      done_cnt++;
      done_log.push_back(Data);
      last_done_cyc = cyc;
    end
    if (Frame_err) ferr_cnt++;
    if ((Rx_done && prev_done) || (Frame_err && prev_ferr) || (Rx_done && Frame_err))
      wide_cnt++;
    prev_done = Rx_done;
    prev_ferr = Frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input real bit_ns,
                            input logic stop_val, input logic idle_val);
    uart_rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      #(bit_ns);
    end
    uart_rx = stop_val;
    #(bit_ns);
    uart_rx = idle_val;
  endtask

  int d0;
  int f0;
  int t0;
  int lat;
  logic [7:0] burst [0:4];
  logic [7:0] mm_byte [0:3];
  real        mm_fac  [0:3];

  initial begin
    burst   = '{8'hBB, 8'hFC, 8'h33, 8'hCC, 8'h11};
    mm_byte = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    mm_fac  = '{1.02, 1.02, 0.98, 0.98};

    repeat (5) @(posedge clk);
    #1;
    check("reset_data", Data, 8'h00);
    check("reset_rx_done", Rx_done, 1'b0);
    check("reset_frame_err", Frame_err, 1'b0);
    @(negedge clk);
    n_reset = 1'b1;
    repeat (20) @(posedge clk);

    // Single byte at 9600, with start-edge-to-strobe latency
    @(negedge clk);
    t0 = cyc;
    send_frame(8'h55, B0_NS, 1'b1, 1'b1);
    #(B0_NS);
    check("single_count", done_cnt, 1);
    check("single_data", Data, 8'h55);
    check("single_ferr", ferr_cnt, 0);
    lat = last_done_cyc - t0;
    checks++;
    assert (lat >= 3671 && lat <= 3679) else begin
      errors++;
      $error("FAIL single_latency: observed %0d clocks expected 3671..3679", lat);
    end

    // Back-to-back burst at 115200
    Baud_set = 3'd4;
    #(2.0 * B4_NS);
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) send_frame(burst[i], B4_NS, 1'b1, 1'b1);
    #(B4_NS);
    check("burst_count", done_cnt - d0, 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("burst_byte%0d", i), done_log[d0 + i], burst[i]);

    // Rate select changed mid-frame must not affect the frame in flight
    d0 = done_cnt;
    fork
      send_frame(8'h5A, B4_NS, 1'b1, 1'b1);
      begin #(3.0 * B4_NS); Baud_set = 3'd0; end
    join
    #(B4_NS);
    check("baud_latch_count", done_cnt - d0, 1);
    check("baud_latch_data", Data, 8'h5A);
    Baud_set = 3'd4;
    #(B4_NS);

    // Short glitch is rejected, then a real frame
    d0 = done_cnt;
    f0 = ferr_cnt;
    uart_rx = 1'b0;
    #(0.3 * B4_NS);
    uart_rx = 1'b1;
    #(3.0 * B4_NS);
    check("glitch_no_done", done_cnt - d0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);
    send_frame(8'hA5, B4_NS, 1'b1, 1'b1);
    #(B4_NS);
    check("after_glitch_count", done_cnt - d0, 1);
    check("after_glitch_data", Data, 8'hA5);

    // Framing error followed by a held-low line
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, B4_NS, 1'b0, 1'b0);
    #(20.0 * B4_NS);
    check("ferr_count", ferr_cnt - f0, 1);
    check("ferr_no_done", done_cnt - d0, 0);
    check("ferr_data_held", Data, 8'hA5);
    uart_rx = 1'b1;
    #(3.0 * B4_NS);
    check("break_no_retrigger", ferr_cnt - f0, 1);

    // Transmitter rate off by +/-2 %
    for (int i = 0; i < 4; i++) begin
      d0 = done_cnt;
      send_frame(mm_byte[i], B4_NS / mm_fac[i], 1'b1, 1'b1);
      #(B4_NS);
      check($sformatf("mismatch%0d_count", i), done_cnt - d0, 1);
      check($sformatf("mismatch%0d_data", i), Data, mm_byte[i]);
    end

    // Reset during data bit 4 of 0x81
    d0 = done_cnt;
    f0 = ferr_cnt;
    fork
      send_frame(8'h81, B4_NS, 1'b1, 1'b1);
      begin
        #(5.5 * B4_NS);
        n_reset = 1'b0;
        #1;
        check("midreset_data", Data, 8'h00);
        check("midreset_rx_done", Rx_done, 1'b0);
        check("midreset_frame_err", Frame_err, 1'b0);
      end
    join
    #(2.0 * B4_NS);
    n_reset = 1'b1;
    #(3.0 * B4_NS);
    check("midreset_no_strobe", (done_cnt - d0) + (ferr_cnt - f0), 0);
    send_frame(8'h7E, B4_NS, 1'b1, 1'b1);
    #(B4_NS);
    check("post_reset_count", done_cnt - d0, 1);
    check("post_reset_data", Data, 8'h7E);

    check("strobe_width_overlap", wide_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_byte_rx.md
# uart_byte_rx

Byte-level UART receiver: the receive-side counterpart of `uart_byte_tx`, on the consumer side of the serial line. It deserialises 8N1 frames from `uart_rx` using 16× oversampling and majority voting. Each good byte is presented on `Data` with a one-cycle `Rx_done` strobe; frames whose stop bit is low are flagged on `Frame_err`. Multi-byte assemblers sit downstream and consume `Data`/`Rx_done`; the 40-bit word sender drives the far end.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz; sets the oversample divider.
- `clk`  in  1  system clock, rising edge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `uart_rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `Baud_set`  in  3  rate select, same encoding as `uart_byte_tx`:
  - 0 = 9600, 1 = 19200, 2 = 38400, 3 = 57600, 4 = 115200;
  - 5–7 = 115200.
- `Data`  out  8  last correctly received byte, LSB first on the line.
- `Rx_done`  out  1  one-cycle pulse; `Data` is valid from the same cycle.
- `Frame_err`  out  1  one-cycle pulse; stop bit sampled low.

## Operation
- **Synchroniser:** 2-FF on `uart_rx` (reset value 1), then a 1-FF delayed copy for edge detection.
- **Tick divider:** `DIV = CLK_FREQ/(baud*16) - 1`, integer division.
  - Counts 0..`DIV`; emits `tick` at `DIV`, then wraps to 0.
  - Cleared to 0 on start-edge detection so the bit grid aligns to the edge.
- **Sub-counter:** 4-bit `os_cnt` advances on each `tick`; 0..15 is one bit period.
- **Bit sampling:** line sampled at `os_cnt` 7, 8, 9; bit value = majority of the three.
- **FSM:**
  - **IDLE:** on a synchronised falling edge → START; latch `Baud_set`; clear divider, `os_cnt` and bit index.
  - **START:** at the tick where `os_cnt` = 9, voted 0 → continue; voted 1 → IDLE (glitch rejected, no output). At `os_cnt` 15 → DATA.
  - **DATA:** at `os_cnt` 9, vote shifted into `shreg[bit_idx]` (LSB first). At `os_cnt` 15, `bit_idx` increments; after bit 7 → STOP.
  - **STOP:** at `os_cnt` 9:
    - vote 1 → `Data <= shreg`, `Rx_done` pulses;
    - vote 0 → `Frame_err` pulses, `Data` held;
    - either way → IDLE immediately (half bit early, so back-to-back frames are accepted).
- **Baud latch:** changes to `Baud_set` mid-frame are ignored; the latched value applies until the next IDLE→START transition.
- **Line held low (break):** after `Frame_err`, IDLE waits for a new falling edge. A constant-low line never retriggers.
- **Reset values:** `Data` = 8'h00, `Rx_done` = 0, `Frame_err` = 0, FSM = IDLE, all counters 0, synchronisers 1.
- **Reset mid-frame:** the partial byte is discarded and no strobe is issued. After reset release the receiver waits for the next falling edge, which may fall mid-frame and yield a garbage byte or `Frame_err`. That outcome is acceptable.

## Timing
- **Edge detect latency:** 3 clocks from the `uart_rx` transition to the IDLE→START transition.
- **Strobe timing:** `Rx_done`/`Frame_err` are registered and asserted in the cycle after the `os_cnt` = 9 tick of the stop bit.
  - That is ≈ 9.56 bit periods + 4 clocks after the start edge on the line.
- **Pulse width:** both strobes are exactly 1 clock wide and never asserted together.
- **Clock tolerance:** correct reception with up to ±2 % mismatch between transmitter and receiver baud.
- **Back-to-back frames:** the minimum accepted inter-frame gap is 0 (stop bit immediately followed by a start bit).

## Structure
- **Package `uart_pkg`:**
  - baud-rate table indexed by `Baud_set`;
  - function `div_for(clk_freq, baud)`;
  - oversample constants (16; sample points 7/8/9);
  - FSM state encoding.
  - `uart_byte_tx` shares this package.
- **Sub-module `uart_rx_sync`:** 2-FF synchroniser plus falling-edge detector; reusable for other asynchronous inputs.
- Everything else is a single module: divider, `os_cnt`, voter, FSM, shift register.

## Test plan
- **Single byte:** `Baud_set` = 0, CLK_FREQ = 50 MHz, send 0x55 → one `Rx_done`, `Data` = 8'h55, `Frame_err` never high.
- **Loopback burst:** `uart_byte_tx` → `uart_byte_rx` at `Baud_set` = 4, send 0xBB, 0xFC, 0x33, 0xCC, 0x11 back-to-back → five `Rx_done` pulses with `Data` in that order.
- **Glitch rejection:** 0.3-bit low pulse on an idle line → no `Rx_done`, no `Frame_err`, FSM back in IDLE; a following 0xA5 frame is received correctly.
- **Framing error:** 0x3C with stop bit forced low → one `Frame_err` pulse, `Data` keeps its previous value, no `Rx_done`.
- **Baud mismatch:** transmitter at 115200 × 1.02 and × 0.98, send 0x00 and 0xFF → both received correctly.
- **Reset mid-frame:** assert `n_reset` during data bit 4 of 0x81 → all outputs 0 immediately. Then send 0x7E on a clean line → `Data` = 8'h7E with a single `Rx_done`.
